// File: rtl/irq_receiver_pkg.sv
// -----------------------------------------------------------------------------
// irq_receiver_pkg
//   Shared types for the external interrupt receiver:
//   - IRQ_IDX_W     : width of an interrupt index / vector table address
//   - irq_state_e   : receiver FSM encodings (IDLE / REQ / SERVICE)
//   - irq_pick_t    : result of the priority search (found flag + index)
// -----------------------------------------------------------------------------
package irq_receiver_pkg;

  localparam int IRQ_IDX_W = 5;

  typedef enum logic [1:0] {
    IRQ_STATE_IDLE    = 2'd0,
    IRQ_STATE_REQ     = 2'd1,
    IRQ_STATE_SERVICE = 2'd2
  } irq_state_e;

  typedef struct packed {
    logic                 found;
    logic [IRQ_IDX_W-1:0] idx;
  } irq_pick_t;

endpackage

// File: rtl/irq_edge_sync.sv
// -----------------------------------------------------------------------------
// irq_edge_sync
//   Synchronises one asynchronous interrupt line through SYNC flops and emits a
//   one-cycle pulse on each synchronised 0->1 transition.
//
//   Ports:
//     clk_i   in  1  system clock, rising edge
//     rst_ni  in  1  asynchronous active-low reset
//     irq_i   in  1  raw asynchronous interrupt line, active high
//     rise_o  out 1  single-cycle rising-edge pulse (combinational from flops)
//
//   A line already high when reset is released must not look like a fresh
//   edge, so the detector stays disarmed until the chain and the previous-
//   value flop both hold real samples of the line (SYNC+1 cycles).
// -----------------------------------------------------------------------------
module irq_edge_sync #(
  parameter int SYNC = 2
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic irq_i,
  output logic rise_o
);

  logic [SYNC-1:0] sync_q;
  logic            prev_q;
  logic [SYNC:0]   arm_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      arm_q  <= '0;
    end else begin
      sync_q <= {sync_q[SYNC-2:0], irq_i};
      prev_q <= sync_q[SYNC-1];
      arm_q  <= {arm_q[SYNC-1:0], 1'b1};
    end
  end

  assign rise_o = sync_q[SYNC-1] & ~prev_q & arm_q[SYNC];

endmodule

// File: rtl/irq_receiver.sv
// -----------------------------------------------------------------------------
// irq_receiver
//   Core-side end of the external interrupt lines. Each line is synchronised
//   and edge-detected, rising edges latch pending bits, a mask selects the
//   eligible ones, one winner is arbitrated and its vector from the vecs[]
//   table is presented to the core. In-service state is tracked until eoi.
//
//   Ports:
//     clk        in   1        system clock, rising edge
//     reset_n    in   1        asynchronous active-low reset
//     irqs       in   NIRQ     raw async interrupt lines, active high
//     mask_we    in   1        load mask register from mask_d
//     mask_d     in   NIRQ     new mask (1 = enabled)
//     vec_we     in   1        write vecs[vec_addr] <= vec_d
//     vec_addr   in   5        vector table index
//     vec_d      in   VECW     vector data
//     irq_req    out  1        interrupt request to core
//     irq_num    out  5        index of presented interrupt
//     irq_vec    out  VECW     latched vector of presented interrupt
//     irq_ack    in   1        core accepts presented interrupt
//     eoi        in   1        core finished servicing current interrupt
//     pending    out  NIRQ     pending register (debug/readback)
//     dbg_state  out  2        current FSM state
//
//   Core handshake: irq_req is raised with irq_num/irq_vec already stable and
//   they stay unchanged while irq_req=1. A cycle with irq_req=1 and irq_ack=1
//   is the transfer: the pending bit is cleared and irq_req falls on that same
//   edge. The core then owns the interrupt until it pulses eoi; no new request
//   is raised in between. irq_req can also fall without an ack if the
//   presented line is masked off.
//
//   Configuration macro IRQ_ROTATE_PRIO_EN:
//     undefined - fixed priority, lowest index wins
//     defined   - round-robin, search starts after the last acked index
// -----------------------------------------------------------------------------
module irq_receiver
  import irq_receiver_pkg::*;
#(
  parameter int NIRQ = 32,
  parameter int VECW = 32,
  parameter int SYNC = 2
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic [NIRQ-1:0]      irqs,
  input  logic                 mask_we,
  input  logic [NIRQ-1:0]      mask_d,
  input  logic                 vec_we,
  input  logic [IRQ_IDX_W-1:0] vec_addr,
  input  logic [VECW-1:0]      vec_d,
  output logic                 irq_req,
  output logic [IRQ_IDX_W-1:0] irq_num,
  output logic [VECW-1:0]      irq_vec,
  input  logic                 irq_ack,
  input  logic                 eoi,
  output logic [NIRQ-1:0]      pending,
  output irq_state_e           dbg_state
);

  // ---------------------------------------------------------------------------
  // Per-line synchroniser and rising-edge detector
  // ---------------------------------------------------------------------------
  logic [NIRQ-1:0] rise;

  for (genvar g = 0; g < NIRQ; g++) begin : g_sync
    irq_edge_sync #(
      .SYNC (SYNC)
    ) u_sync (
      .clk_i  (clk),
      .rst_ni (reset_n),
      .irq_i  (irqs[g]),
      .rise_o (rise[g])
    );
  end

  // ---------------------------------------------------------------------------
  // Vector table: deliberately not reset, software (or the bench) loads it.
  // ---------------------------------------------------------------------------
  logic [VECW-1:0] vecs [NIRQ];

  always_ff @(posedge clk) begin
    if (vec_we && (int'(vec_addr) < NIRQ)) begin
      vecs[vec_addr] <= vec_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Priority search. Walking from the lowest-priority slot towards the
  // highest lets the last hit win, so no early loop exit is needed.
  // ---------------------------------------------------------------------------
  function automatic irq_pick_t pick_winner(input logic [NIRQ-1:0] elig,
                                            input int              start);
    irq_pick_t            p;
    int                   j;
    logic [IRQ_IDX_W-1:0] jj;
    p = '0;
    for (int k = NIRQ - 1; k >= 0; k--) begin
      j = start + k;
      if (j >= NIRQ) begin
        j = j - NIRQ;
      end
      jj = IRQ_IDX_W'(j);
      if (elig[jj]) begin
        p.found = 1'b1;
        p.idx   = jj;
      end
    end
    return p;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  irq_state_e           state_q, state_d;
  logic [NIRQ-1:0]      pending_q, pending_d;
  logic [NIRQ-1:0]      mask_q;
  logic [IRQ_IDX_W-1:0] irq_num_q, irq_num_d;
  logic [VECW-1:0]      irq_vec_q, irq_vec_d;
  logic [NIRQ-1:0]      clr;
  logic                 ack_take;
  irq_pick_t            win;
  int                   start_idx;

`ifdef IRQ_ROTATE_PRIO_EN
  // Index of the last acknowledged interrupt; the search begins one past it
  // so the interrupt just serviced becomes the lowest priority.
  logic [IRQ_IDX_W-1:0] last_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_q <= '0;
    end else if (ack_take) begin
      last_q <= irq_num_q;
    end
  end

  always_comb begin
    start_idx = int'(last_q) + 1;
    if (start_idx >= NIRQ) begin
      start_idx = 0;
    end
  end
`else
  always_comb begin
    start_idx = 0;
  end
`endif

  // ---------------------------------------------------------------------------
  // FSM next-state and datapath
  // ---------------------------------------------------------------------------
  always_comb begin
    state_d   = state_q;
    irq_num_d = irq_num_q;
    irq_vec_d = irq_vec_q;
    clr       = '0;
    ack_take  = 1'b0;
    win       = pick_winner(pending_q & mask_q, start_idx);

    case (state_q)
      IRQ_STATE_IDLE: begin
        if (win.found) begin
          state_d   = IRQ_STATE_REQ;
          irq_num_d = win.idx;
          irq_vec_d = vecs[win.idx];
        end
      end
      IRQ_STATE_REQ: begin
        // Ack has precedence over a same-cycle eoi (ignored here) and over a
        // same-cycle mask-off of the winner.
        if (irq_ack) begin
          state_d        = IRQ_STATE_SERVICE;
          clr[irq_num_q] = 1'b1;
          ack_take       = 1'b1;
        end else if (!mask_q[irq_num_q]) begin
          state_d = IRQ_STATE_IDLE;
        end
      end
      IRQ_STATE_SERVICE: begin
        if (eoi) begin
          state_d = IRQ_STATE_IDLE;
        end
      end
      default: begin
        state_d = IRQ_STATE_IDLE;
      end
    endcase
  end

  // A new edge on the bit being acked in the same cycle keeps it pending.
  assign pending_d = (pending_q & ~clr) | rise;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IRQ_STATE_IDLE;
      pending_q <= '0;
      mask_q    <= '0;
      irq_num_q <= '0;
      irq_vec_q <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      irq_num_q <= irq_num_d;
      irq_vec_q <= irq_vec_d;
      if (mask_we) begin
        mask_q <= mask_d;
      end
    end
  end

  assign irq_req   = (state_q == IRQ_STATE_REQ);
  assign irq_num   = irq_num_q;
  assign irq_vec   = irq_vec_q;
  assign pending   = pending_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_irq_receiver.sv
// -----------------------------------------------------------------------------
// tb_irq_receiver
//   Directed bench for irq_receiver. Inputs change 1 time unit after a rising
//   edge and outputs are sampled at that same point, away from the edge.
//   Default build expects fixed priority; with IRQ_ROTATE_PRIO_EN defined the
//   arbitration expectations of the two-line scenario switch to round-robin.
// -----------------------------------------------------------------------------
module tb_irq_receiver;
  import irq_receiver_pkg::*;

  localparam int NIRQ = 32;
  localparam int VECW = 32;

  // ---------------------------------------------------------------------------
  // Clock / reset
  // ---------------------------------------------------------------------------
  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic [NIRQ-1:0] irqs = '0;
  logic            mask_we = 1'b0;
  logic [NIRQ-1:0] mask_d = '0;
  logic            vec_we = 1'b0;
  logic [4:0]      vec_addr = '0;
  logic [VECW-1:0] vec_d = '0;
  logic            irq_ack = 1'b0;
  logic            eoi = 1'b0;
  logic            irq_req;
  logic [4:0]      irq_num;
  logic [VECW-1:0] irq_vec;
  logic [NIRQ-1:0] pending;
  irq_state_e      dbg_state;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  irq_receiver #(
    .NIRQ (NIRQ),
    .VECW (VECW),
    .SYNC (2)
  ) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .irqs      (irqs),
    .mask_we   (mask_we),
    .mask_d    (mask_d),
    .vec_we    (vec_we),
    .vec_addr  (vec_addr),
    .vec_d     (vec_d),
    .irq_req   (irq_req),
    .irq_num   (irq_num),
    .irq_vec   (irq_vec),
    .irq_ack   (irq_ack),
    .eoi       (eoi),
    .pending   (pending),
    .dbg_state (dbg_state)
  );

  // ---------------------------------------------------------------------------
  // Driver helpers
  // ---------------------------------------------------------------------------
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [VECW-1:0] exp_vec(input int i);
    if (i == 3) return 32'h0000_0100;
    return 32'hA000_0000 | VECW'(i << 4);
  endfunction

  task automatic write_mask(input logic [NIRQ-1:0] m);
    mask_we = 1'b1;
    mask_d  = m;
    step(1);
    mask_we = 1'b0;
  endtask

  // ---------------------------------------------------------------------------
  // Scenarios
  // ---------------------------------------------------------------------------
  task automatic test_reset();
    #12;
    checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL rst_req got=%0b exp=0", irq_req); end
    checks++; if (irq_num !== 5'd0) begin failures++; $display("FAIL rst_num got=%0d exp=0", irq_num); end
    checks++; if (irq_vec !== 32'h0) begin failures++; $display("FAIL rst_vec got=%h exp=0", irq_vec); end
    checks++; if (pending !== 32'h0) begin failures++; $display("FAIL rst_pending got=%h exp=0", pending); end
    checks++; if (dbg_state !== IRQ_STATE_IDLE) begin failures++; $display("FAIL rst_state got=%0d exp=0", dbg_state); end
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    step(1);
    for (int i = 0; i < NIRQ; i++) begin
      vec_we   = 1'b1;
      vec_addr = 5'(i);
      vec_d    = exp_vec(i);
      step(1);
    end
    vec_we = 1'b0;
    write_mask('1);
    step(1);
    checks++; if (pending !== 32'h0) begin failures++; $display("FAIL init_pending got=%h exp=0", pending); end
  endtask

  task automatic test_single();
    irqs[3] = 1'b1;
    step(2);
    irqs[3] = 1'b0;
    checks++; if (pending !== 32'h0) begin failures++; $display("FAIL t1_early_pending got=%h exp=0", pending); end
    step(1);
    checks++; if (pending !== 32'h8) begin failures++; $display("FAIL t1_pending got=%h exp=8", pending); end
    checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL t1_req_early got=%0b exp=0", irq_req); end
    step(1);
    checks++; if (irq_req !== 1'b1) begin failures++; $display("FAIL t1_req got=%0b exp=1", irq_req); end
    checks++; if (irq_num !== 5'd3) begin failures++; $display("FAIL t1_num got=%0d exp=3", irq_num); end
    checks++; if (irq_vec !== 32'h100) begin failures++; $display("FAIL t1_vec got=%h exp=100", irq_vec); end
    irq_ack = 1'b1;
    step(1);
    irq_ack = 1'b0;
    checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL t1_req_after_ack got=%0b exp=0", irq_req); end
    checks++; if (dbg_state !== IRQ_STATE_SERVICE) begin failures++; $display("FAIL t1_service got=%0d exp=2", dbg_state); end
    checks++; if (pending !== 32'h0) begin failures++; $display("FAIL t1_pending_clr got=%h exp=0", pending); end
    eoi = 1'b1;
    step(1);
    eoi = 1'b0;
    checks++; if (dbg_state !== IRQ_STATE_IDLE) begin failures++; $display("FAIL t1_idle got=%0d exp=0", dbg_state); end
    step(1);
  endtask

  task automatic test_arbitration();
    int first;
    int second;
    logic [NIRQ-1:0] exp_p;
`ifdef IRQ_ROTATE_PRIO_EN
    first  = 5;  // last acked was 3, search starts at 4
    second = 2;
`else
    first  = 2;
    second = 5;
`endif
    irqs[5] = 1'b1;
    irqs[2] = 1'b1;
    step(2);
    irqs[5] = 1'b0;
    irqs[2] = 1'b0;
    step(1);
    checks++; if (pending !== 32'h24) begin failures++; $display("FAIL t2_pending got=%h exp=24", pending); end
    step(1);
    checks++; if (irq_num !== 5'(first)) begin failures++; $display("FAIL t2_first_num got=%0d exp=%0d", irq_num, first); end
    checks++; if (irq_vec !== exp_vec(first)) begin failures++; $display("FAIL t2_first_vec got=%h exp=%h", irq_vec, exp_vec(first)); end
    irq_ack = 1'b1;
    step(1);
    exp_p = 32'h24 & ~(32'h1 << first);
    checks++; if (pending !== exp_p) begin failures++; $display("FAIL t2_pending_ack got=%h exp=%h", pending, exp_p); end
    // ack while in SERVICE must be ignored
    step(1);
    irq_ack = 1'b0;
    checks++; if (pending !== exp_p) begin failures++; $display("FAIL t2_stray_ack got=%h exp=%h", pending, exp_p); end
    checks++; if (dbg_state !== IRQ_STATE_SERVICE) begin failures++; $display("FAIL t2_stray_ack_state got=%0d exp=2", dbg_state); end
    eoi = 1'b1;
    step(1);
    eoi = 1'b0;
    checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL t2_gap_req got=%0b exp=0", irq_req); end
    step(1);
    checks++; if (irq_req !== 1'b1) begin failures++; $display("FAIL t2_second_req got=%0b exp=1", irq_req); end
    checks++; if (irq_num !== 5'(second)) begin failures++; $display("FAIL t2_second_num got=%0d exp=%0d", irq_num, second); end
    checks++; if (irq_vec !== exp_vec(second)) begin failures++; $display("FAIL t2_second_vec got=%h exp=%h", irq_vec, exp_vec(second)); end
    // eoi while in REQ must be ignored
    eoi = 1'b1;
    step(1);
    eoi = 1'b0;
    checks++; if (dbg_state !== IRQ_STATE_REQ) begin failures++; $display("FAIL t2_stray_eoi got=%0d exp=1", dbg_state); end
    // simultaneous ack+eoi in REQ: ack wins
    irq_ack = 1'b1;
    eoi     = 1'b1;
    step(1);
    irq_ack = 1'b0;
    eoi     = 1'b0;
    checks++; if (dbg_state !== IRQ_STATE_SERVICE) begin failures++; $display("FAIL t2_ack_eoi got=%0d exp=2", dbg_state); end
    checks++; if (pending !== 32'h0) begin failures++; $display("FAIL t2_pending_end got=%h exp=0", pending); end
    eoi = 1'b1;
    step(1);
    eoi = 1'b0;
    step(1);
  endtask

  task automatic test_mask();
    write_mask('0);
    irqs[7] = 1'b1;
    step(2);
    irqs[7] = 1'b0;
    step(1);
    checks++; if (pending !== 32'h80) begin failures++; $display("FAIL t3_pending got=%h exp=80", pending); end
    step(2);
    checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL t3_masked_req got=%0b exp=0", irq_req); end
    write_mask(32'h80);
    checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL t3_mask_latency got=%0b exp=0", irq_req); end
    step(1);
    checks++; if (irq_req !== 1'b1) begin failures++; $display("FAIL t3_req got=%0b exp=1", irq_req); end
    checks++; if (irq_num !== 5'd7) begin failures++; $display("FAIL t3_num got=%0d exp=7", irq_num); end
    // table write to the presented index must not disturb the latched vector
    vec_we   = 1'b1;
    vec_addr = 5'd7;
    vec_d    = 32'hDEAD_BEEF;
    step(1);
    vec_we = 1'b0;
    checks++; if (irq_vec !== exp_vec(7)) begin failures++; $display("FAIL t3_vec_held got=%h exp=%h", irq_vec, exp_vec(7)); end
    // mask the winner off while requesting
    write_mask('0);
    checks++; if (irq_req !== 1'b1) begin failures++; $display("FAIL t3_req_before_drop got=%0b exp=1", irq_req); end
    step(1);
    checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL t3_req_drop got=%0b exp=0", irq_req); end
    checks++; if (pending !== 32'h80) begin failures++; $display("FAIL t3_pending_kept got=%h exp=80", pending); end
    write_mask('1);
    step(1);
    checks++; if (irq_vec !== 32'hDEAD_BEEF) begin failures++; $display("FAIL t3_vec_new got=%h exp=deadbeef", irq_vec); end
    irq_ack = 1'b1;
    step(1);
    irq_ack = 1'b0;
    eoi = 1'b1;
    step(1);
    eoi = 1'b0;
    step(1);
    checks++; if (pending !== 32'h0) begin failures++; $display("FAIL t3_pending_end got=%h exp=0", pending); end
  endtask

  task automatic test_service_block();
    irqs[1] = 1'b1;
    step(2);
    irqs[1] = 1'b0;
    step(2);
    checks++; if (irq_num !== 5'd1) begin failures++; $display("FAIL t4_num got=%0d exp=1", irq_num); end
    irq_ack = 1'b1;
    step(1);
    irq_ack = 1'b0;
    irqs[1] = 1'b1;
    step(2);
    irqs[1] = 1'b0;
    step(1);
    checks++; if (pending !== 32'h2) begin failures++; $display("FAIL t4_repend got=%h exp=2", pending); end
    step(2);
    checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL t4_req_in_service got=%0b exp=0", irq_req); end
    checks++; if (dbg_state !== IRQ_STATE_SERVICE) begin failures++; $display("FAIL t4_state got=%0d exp=2", dbg_state); end
    eoi = 1'b1;
    step(1);
    eoi = 1'b0;
    step(1);
    checks++; if (irq_req !== 1'b1) begin failures++; $display("FAIL t4_second_req got=%0b exp=1", irq_req); end
    checks++; if (irq_num !== 5'd1) begin failures++; $display("FAIL t4_second_num got=%0d exp=1", irq_num); end
    irq_ack = 1'b1;
    step(1);
    irq_ack = 1'b0;
    eoi = 1'b1;
    step(1);
    eoi = 1'b0;
    step(1);
  endtask

  task automatic test_set_wins();
    irqs[4] = 1'b1;
    step(2);
    irqs[4] = 1'b0;
    step(2);
    checks++; if (irq_num !== 5'd4) begin failures++; $display("FAIL t5_num got=%0d exp=4", irq_num); end
    irqs[4] = 1'b1;
    step(2);
    irqs[4] = 1'b0;
    irq_ack = 1'b1;
    step(1);
    irq_ack = 1'b0;
    checks++; if (pending !== 32'h10) begin failures++; $display("FAIL t5_set_wins got=%h exp=10", pending); end
    eoi = 1'b1;
    step(1);
    eoi = 1'b0;
    step(1);
    checks++; if (irq_req !== 1'b1 || irq_num !== 5'd4) begin failures++; $display("FAIL t5_represent got=%0b/%0d exp=1/4", irq_req, irq_num); end
    irq_ack = 1'b1;
    step(1);
    irq_ack = 1'b0;
    eoi = 1'b1;
    step(1);
    eoi = 1'b0;
    step(1);
    checks++; if (pending !== 32'h0) begin failures++; $display("FAIL t5_pending_end got=%h exp=0", pending); end
  endtask

  task automatic test_reset_mid_req();
    irqs[6] = 1'b1;
    step(4);
    checks++; if (irq_req !== 1'b1 || irq_num !== 5'd6) begin failures++; $display("FAIL t6_req got=%0b/%0d exp=1/6", irq_req, irq_num); end
    #2;
    reset_n = 1'b0;
    #1;
    checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL t6_async_req got=%0b exp=0", irq_req); end
    checks++; if (pending !== 32'h0) begin failures++; $display("FAIL t6_async_pending got=%h exp=0", pending); end
    checks++; if (irq_num !== 5'd0) begin failures++; $display("FAIL t6_async_num got=%0d exp=0", irq_num); end
    checks++; if (dbg_state !== IRQ_STATE_IDLE) begin failures++; $display("FAIL t6_async_state got=%0d exp=0", dbg_state); end
    step(2);
    reset_n = 1'b1;
    step(6);
    checks++; if (pending !== 32'h0) begin failures++; $display("FAIL t6_level_pending got=%h exp=0", pending); end
    write_mask('1);
    step(3);
    checks++; if (irq_req !== 1'b0) begin failures++; $display("FAIL t6_spurious_req got=%0b exp=0", irq_req); end
    checks++; if (pending !== 32'h0) begin failures++; $display("FAIL t6_pending_end got=%h exp=0", pending); end
    irqs[6] = 1'b0;
    step(2);
  endtask

  // ---------------------------------------------------------------------------
  // Sequence and report
  // ---------------------------------------------------------------------------
  initial begin
    test_reset();
    test_single();
    test_arbitration();
    test_mask();
    test_service_block();
    test_set_wins();
    test_reset_mid_req();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
